// File: rtl/gate_test_pkg.sv
// Shared encodings for the gate test sequencer.
// Gate-select codes, FSM states and the select validity check.
package gate_test_pkg;

  localparam logic [2:0] SEL_AND  = 3'b000;
  localparam logic [2:0] SEL_OR   = 3'b001;
  localparam logic [2:0] SEL_NAND = 3'b010;
  localparam logic [2:0] SEL_NOR  = 3'b011;
  localparam logic [2:0] SEL_XOR  = 3'b100;
  localparam logic [2:0] SEL_XNOR = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic is_valid_sel(input logic [2:0] sel);
    return sel <= SEL_XNOR;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Loadable down-counter that times the settle window after a vector.
// Holds at zero once expired until reloaded.
module settle_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks a quad 2-input gate IC through its four truth-table vectors
// and compares every pin against the reference mux output.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_GATES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           gate_sel,
  input  logic                 exp_y,
  input  logic [NUM_GATES-1:0] ic_out,
  output logic [2:0]           select,
  output logic [NUM_GATES-1:0] test_a,
  output logic [NUM_GATES-1:0] test_b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic                 bad_sel
);

  localparam int TW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic [1:0]           vec;
  logic [1:0]           vec_next;
  logic [2:0]           select_next;
  logic [NUM_GATES-1:0] fail_next;
  logic [NUM_GATES-1:0] mism;
  logic                 pass_next;
  logic                 bad_next;
  logic                 load;
  logic                 expired;

  settle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (SETTLE_LOAD),
    .expired  (expired)
  );

  // Only consumed in SAMPLE, so an undriven mux output is never used.
  assign mism = ic_out ^ {NUM_GATES{exp_y}};

  always_comb begin
    state_next  = state;
    vec_next    = vec;
    select_next = select;
    fail_next   = fail_mask;
    pass_next   = pass;
    bad_next    = bad_sel;
    load        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    test_a      = '0;
    test_b      = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          select_next = gate_sel;
          fail_next   = '0;
          pass_next   = 1'b0;
          bad_next    = ~is_valid_sel(gate_sel);
          vec_next    = 2'd0;
          state_next  = is_valid_sel(gate_sel) ? APPLY : DONE;
        end
      end
      APPLY: begin
        busy       = 1'b1;
        test_a     = {NUM_GATES{vec[1]}};
        test_b     = {NUM_GATES{vec[0]}};
        load       = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        busy   = 1'b1;
        test_a = {NUM_GATES{vec[1]}};
        test_b = {NUM_GATES{vec[0]}};
        if (expired) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        busy      = 1'b1;
        test_a    = {NUM_GATES{vec[1]}};
        test_b    = {NUM_GATES{vec[0]}};
        fail_next = fail_mask | mism;
        if (vec == 2'd3) begin
          pass_next  = ~bad_sel & ~|fail_next;
          state_next = DONE;
        end else begin
          vec_next   = vec + 2'd1;
          state_next = APPLY;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= 2'd0;
      select    <= 3'd0;
      fail_mask <= '0;
      pass      <= 1'b0;
      bad_sel   <= 1'b0;
    end else begin
      state     <= state_next;
      vec       <= vec_next;
      select    <= select_next;
      fail_mask <= fail_next;
      pass      <= pass_next;
      bad_sel   <= bad_next;
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench for gate_test_sequencer: emulates a faulty IC and
// the reference mux, and predicts results from a truth-table model.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  localparam int S    = 4;
  localparam int N    = 4;
  localparam int VLEN = S + 2;
  localparam int LAT  = 4 * VLEN;

  typedef struct packed {
    int         lat;
    int         ndone;
    bit         drive_ok;
    bit         overlap;
    logic       pass;
    logic [N-1:0] mask;
    logic       bad;
    logic [2:0] sel;
  } res_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   gate_sel = 3'd0;
  logic         exp_y;
  logic [N-1:0] ic_out;
  logic [2:0]   select;
  logic [N-1:0] test_a;
  logic [N-1:0] test_b;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N-1:0] fail_mask;
  logic         bad_sel;

  logic [2:0]   ic_kind = SEL_AND;
  logic [N-1:0] stuck0 = '0;
  logic [N-1:0] stuck1 = '0;
  logic [N-1:0] invert = '0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gate_test_sequencer #(
    .SETTLE_CYCLES(S),
    .NUM_GATES(N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .gate_sel  (gate_sel),
    .exp_y     (exp_y),
    .ic_out    (ic_out),
    .select    (select),
    .test_a    (test_a),
    .test_b    (test_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .bad_sel   (bad_sel)
  );

  function automatic logic gate_fn(input logic [2:0] s, input logic a, input logic b);
    case (s)
      SEL_AND:  return a & b;
      SEL_OR:   return a | b;
      SEL_NAND: return ~(a & b);
      SEL_NOR:  return ~(a | b);
      SEL_XOR:  return a ^ b;
      SEL_XNOR: return ~(a ^ b);
      default:  return 1'b0;
    endcase
  endfunction

  // IC under test with injectable faults, plus the reference mux.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ic_out[i] = stuck1[i] ? 1'b1 : stuck0[i] ? 1'b0 :
                  gate_fn(ic_kind, test_a[i], test_b[i]) ^ invert[i];
    end
    exp_y = is_valid_sel(select) ? gate_fn(select, test_a[0], test_b[0]) : 1'bx;
  end

  function automatic logic [N-1:0] model_mask(input logic [2:0] sel, input logic [2:0] kind,
                                              input logic [N-1:0] s0, input logic [N-1:0] s1,
                                              input logic [N-1:0] inv);
    logic [N-1:0] m;
    logic a, b, y, o;
    m = '0;
    if (!is_valid_sel(sel)) return m;
    for (int v = 0; v < 4; v++) begin
      a = (v >= 2);
      b = (v % 2 == 1);
      y = gate_fn(sel, a, b);
      for (int i = 0; i < N; i++) begin
        o = s1[i] ? 1'b1 : s0[i] ? 1'b0 : gate_fn(kind, a, b) ^ inv[i];
        if (o != y) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Pulses start, then watches a bounded window; k counts cycles after the start edge.
  task automatic run_test(input logic [2:0] sel, input int restart_at,
                          input logic [2:0] sel2, output res_t r);
    logic valid;
    logic ebusy;
    logic [N-1:0] ea, eb;
    int vi;
    valid = is_valid_sel(sel);
    r = '0;
    r.lat = -1;
    r.drive_ok = 1'b1;
    @(negedge clk);
    gate_sel = sel;
    start = 1'b1;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && done) r.overlap = 1'b1;
      if (done) begin
        r.ndone = r.ndone + 1;
        if (r.lat < 0) begin
          r.lat  = k;
          r.pass = pass;
          r.mask = fail_mask;
          r.bad  = bad_sel;
          r.sel  = select;
        end
      end
      ebusy = valid && (k <= LAT);
      vi = (k - 1) / VLEN;
      ea = ebusy ? {N{vi[1]}} : '0;
      eb = ebusy ? {N{vi[0]}} : '0;
      if (test_a !== ea || test_b !== eb || busy !== ebusy) r.drive_ok = 1'b0;
      gate_sel = 3'($urandom);
      if (k == restart_at) begin
        gate_sel = sel2;
        start = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    gate_sel = SEL_OR;
    repeat (2) @(negedge clk);
    checks++;
    if ({select, test_a, test_b, busy, done, pass, fail_mask, bad_sel} !== '0)
      $display("FAIL reset_outputs: got sel=%b a=%b b=%b busy=%b done=%b pass=%b mask=%b bad=%b required all 0",
               select, test_a, test_b, busy, done, pass, fail_mask, bad_sel);
    else passed++;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || select !== 3'd0)
      $display("FAIL reset_wins_start: got busy=%b sel=%b required 0/000", busy, select);
    else passed++;
  endtask

  task automatic test_and_good();
    res_t r;
    ic_kind = SEL_AND; stuck0 = '0; stuck1 = '0; invert = '0;
    run_test(SEL_AND, 0, 3'd0, r);
    checks++;
    if (r.lat - 1 !== LAT) $display("FAIL t1_latency: got %0d required %0d", r.lat - 1, LAT);
    else passed++;
    checks++;
    if ({r.pass, r.mask, r.bad} !== {1'b1, {N{1'b0}}, 1'b0})
      $display("FAIL t1_result: got pass=%b mask=%b bad=%b required 1/0000/0", r.pass, r.mask, r.bad);
    else passed++;
    checks++;
    if (!r.drive_ok || r.overlap || r.ndone != 1)
      $display("FAIL t1_drive: got drive_ok=%b overlap=%b dones=%0d required 1/0/1",
               r.drive_ok, r.overlap, r.ndone);
    else passed++;
  endtask

  task automatic test_stuck();
    res_t r;
    logic [N-1:0] em;
    ic_kind = SEL_NAND; stuck0 = '0; stuck1 = 4'b0100; invert = '0;
    em = model_mask(SEL_NAND, ic_kind, stuck0, stuck1, invert);
    run_test(SEL_NAND, 0, 3'd0, r);
    checks++;
    if (r.mask !== em || r.pass !== 1'b0)
      $display("FAIL t2_stuck: got mask=%b pass=%b required %b/0", r.mask, r.pass, em);
    else passed++;
    stuck1 = '0;
  endtask

  task automatic test_bad_sel();
    res_t r;
    ic_kind = SEL_AND;
    run_test(3'b111, 0, 3'd0, r);
    checks++;
    if (r.lat !== 1) $display("FAIL t3_done_time: got %0d required 1 cycle after start edge", r.lat);
    else passed++;
    checks++;
    if (r.bad !== 1'b1 || r.pass !== 1'b0 || r.sel !== 3'b111)
      $display("FAIL t3_flags: got bad=%b pass=%b sel=%b required 1/0/111", r.bad, r.pass, r.sel);
    else passed++;
    checks++;
    if (!r.drive_ok || r.ndone != 1)
      $display("FAIL t3_quiet: got drive_ok=%b dones=%0d required 1/1", r.drive_ok, r.ndone);
    else passed++;
  endtask

  task automatic test_reset_mid();
    res_t r;
    int nd;
    ic_kind = SEL_XOR;
    @(negedge clk);
    gate_sel = SEL_XOR;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || test_a !== '1 || test_b !== '0)
      $display("FAIL t4_in_vec10: got busy=%b a=%b b=%b required 1/1111/0000", busy, test_a, test_b);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({select, test_a, test_b, busy, done, pass, fail_mask, bad_sel} !== '0)
      $display("FAIL t4_abort: got sel=%b a=%b b=%b busy=%b done=%b required all 0",
               select, test_a, test_b, busy, done);
    else passed++;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd != 0) $display("FAIL t4_no_done: got %0d done pulses required 0", nd);
    else passed++;
    run_test(SEL_XOR, 0, 3'd0, r);
    checks++;
    if (r.lat - 1 !== LAT || r.pass !== 1'b1)
      $display("FAIL t4_rerun: got latency=%0d pass=%b required %0d/1", r.lat - 1, r.pass, LAT);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    res_t r;
    ic_kind = SEL_OR;
    run_test(SEL_OR, 8, SEL_NAND, r);
    checks++;
    if (r.sel !== SEL_OR || select !== SEL_OR)
      $display("FAIL t5_select: got %b/%b required %b", r.sel, select, SEL_OR);
    else passed++;
    checks++;
    if (r.ndone != 1 || r.pass !== 1'b1 || !r.drive_ok)
      $display("FAIL t5_single: got dones=%0d pass=%b drive_ok=%b required 1/1/1",
               r.ndone, r.pass, r.drive_ok);
    else passed++;
  endtask

  task automatic test_inverted();
    res_t r;
    logic [N-1:0] em;
    ic_kind = SEL_XNOR; invert = '1;
    em = model_mask(SEL_XNOR, ic_kind, stuck0, stuck1, invert);
    run_test(SEL_XNOR, 0, 3'd0, r);
    checks++;
    if (r.mask !== em || r.pass !== 1'b0)
      $display("FAIL t6_inverted: got mask=%b pass=%b required %b/0", r.mask, r.pass, em);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      invert = N'($urandom);
      gate_sel = 3'($urandom);
    end
    checks++;
    if (fail_mask !== em || pass !== 1'b0 || bad_sel !== 1'b0 || select !== SEL_XNOR)
      $display("FAIL t6_hold: got mask=%b pass=%b bad=%b sel=%b required %b/0/0/%b",
               fail_mask, pass, bad_sel, select, em, SEL_XNOR);
    else passed++;
    invert = '0;
  endtask

  task automatic test_random();
    res_t r;
    logic [2:0] sel;
    logic [N-1:0] em;
    logic valid;
    for (int it = 0; it < 24; it++) begin
      sel = 3'($urandom_range(0, 7));
      valid = is_valid_sel(sel);
      ic_kind = (valid && $urandom_range(0, 2) != 0) ? sel : 3'($urandom_range(0, 5));
      stuck0 = N'($urandom & $urandom);
      stuck1 = N'($urandom & $urandom) & ~stuck0;
      invert = N'($urandom & $urandom);
      em = model_mask(sel, ic_kind, stuck0, stuck1, invert);
      run_test(sel, 0, 3'd0, r);
      checks++;
      if (r.lat - 1 !== (valid ? LAT : 0))
        $display("FAIL rnd%0d_latency: got %0d required %0d", it, r.lat - 1, valid ? LAT : 0);
      else passed++;
      checks++;
      if (r.mask !== em) $display("FAIL rnd%0d_mask: got %b required %b", it, r.mask, em);
      else passed++;
      checks++;
      if (r.pass !== (valid && em == '0) || r.bad !== !valid)
        $display("FAIL rnd%0d_flags: got pass=%b bad=%b required %b/%b",
                 it, r.pass, r.bad, valid && em == '0, !valid);
      else passed++;
      checks++;
      if (!r.drive_ok || r.overlap || r.ndone != 1)
        $display("FAIL rnd%0d_drive: got drive_ok=%b overlap=%b dones=%0d required 1/0/1",
                 it, r.drive_ok, r.overlap, r.ndone);
      else passed++;
    end
    stuck0 = '0; stuck1 = '0; invert = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_and_good();
    test_stuck();
    test_bad_sel();
    test_reset_mid();
    test_start_while_busy();
    test_inverted();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
